uart_rx: RTL and testbench
==========================

# uart_rx

UART receive stage consuming the 16x oversample tick `rx_en` from the baud rate generator. Synchronises the serial line, detects start bits and samples each bit at mid-bit. Delivers LSB-first bytes as a one-cycle `rx_valid` strobe with framing and optional parity status. Sits between the pad-side `rx` line and the byte consumer (FIFO/host logic).

## Interface

- `DATA_BITS`, 8, payload bits per frame.
- `SAMPLE_RATE`, 16, `rx_en` ticks per bit period; must be even and at least 4.
- `clk` input 1: system clock, single clock domain.
- `reset` input 1: asynchronous, active-low reset. Asserting it clears all state immediately.
- `rx_en` input 1: oversample tick, one `clk` cycle wide, from the baud rate generator.
- `rx` input 1: asynchronous serial line; idle high.
- `rx_data` output `DATA_BITS`: last received payload, held until the next frame completes.
- `rx_valid` output 1: one-cycle strobe when a frame completes.
- `rx_busy` output 1: high in every state except IDLE.
- `frame_err` output 1: stop bit sampled low on the last frame.
- `parity_err` output 1: parity mismatch on the last frame. Tied 0 when parity is compiled out.

## Operation

- `rx` passes through a 2-flop synchroniser; both flops reset to 1. All sampling uses the synchronised value `rx_s`.
- `tick_cnt` has width `$clog2(SAMPLE_RATE)`. `bit_cnt` has width `$clog2(DATA_BITS+1)`. `shift_reg` has width `DATA_BITS`.
- State only advances on cycles with `rx_en`=1. Only the synchroniser and the `rx_valid` clear run every cycle.
- States:
  - **IDLE**: on a tick with `rx_s`=0, go to START with `tick_cnt`=0.
  - **START**: increment `tick_cnt` each tick. At `tick_cnt`==`SAMPLE_RATE/2-1`, re-sample:
    - `rx_s`=0: go to DATA with `tick_cnt`=0 and `bit_cnt`=0.
    - `rx_s`=1: glitch; go to IDLE with no outputs changed.
  - **DATA**: at `tick_cnt`==`SAMPLE_RATE-1`, do the following, otherwise increment `tick_cnt`:
    - shift right with `rx_s` into the MSB (LSB-first on the wire);
    - set `tick_cnt`=0 and increment `bit_cnt`.
    - After bit `DATA_BITS-1` is sampled, go to PARITY if parity is compiled in, else STOP.
  - **PARITY** (macro only): at `tick_cnt`==`SAMPLE_RATE-1`, latch `par_bad = ^{shift_reg, rx_s}` (even parity), then go to STOP.
  - **STOP**: at `tick_cnt`==`SAMPLE_RATE-1`, on the same edge:
    - `rx_data` <= `shift_reg`;
    - `rx_valid` <= 1;
    - `frame_err` <= ~`rx_s`;
    - `parity_err` <= `par_bad`.
    - Next state is IDLE if `rx_s`=1, else BREAK.
  - **BREAK**: wait for a tick with `rx_s`=1, then go to IDLE. A held-low line therefore never restarts reception.
- `rx_valid` pulses for every completed frame, including errored ones; consumers qualify it with the error flags.
- Error flags and `rx_data` update only together with `rx_valid`.

## Timing

- Reset values: `rx_data`=0, `rx_valid`=0, `rx_busy`=0, `frame_err`=0, `parity_err`=0, state IDLE, all counters 0.
- Start detection latency: 2 `clk` cycles of synchronisation plus up to 1 tick period.
- Each data bit is sampled `SAMPLE_RATE/2` ticks after the bit edge detected in START, i.e. at mid-bit.
- `rx_valid` is high for exactly the one `clk` cycle after the stop-bit sampling edge, then self-clears.
- `rx_busy` rises on the edge that enters START and falls on the edge that enters IDLE. It stays high through BREAK.
- Reset asserted mid-frame aborts the frame: no `rx_valid`, all outputs return to reset values asynchronously.

## Configuration

- `UART_RX_PARITY_EN` defined: frame is start, `DATA_BITS` data bits, one even-parity bit, one stop bit. The PARITY state exists and `parity_err` is driven.
- Not defined: frame is 8N1 (start, data, stop). The PARITY state and `par_bad` are removed and `parity_err` is constant 0.

## Structure

- Package `uart_pkg` holds:
  - the `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - the shared defaults `UART_DATA_BITS`=8 and `UART_SAMPLE_RATE`=16, also used by the baud generator and the transmitter.
- Sub-module `uart_sync2`: a 2-flop synchroniser with a reset-value parameter. It is reusable for other asynchronous inputs.

## Test plan

Bench drives `rx_en` every 4 `clk` cycles and 16 ticks per bit.

- **Normal frame**: 8N1 frame 0xA5 -> one `rx_valid` pulse, `rx_data`=0xA5, `frame_err`=0, `rx_busy` low afterwards.
- **Start glitch**: `rx` low for 4 ticks, then high -> no `rx_valid`; state returns to IDLE; a following 0x3C frame is received correctly.
- **Framing error and break**: frame 0x3C with stop bit low, `rx` held low 40 ticks -> `rx_valid` pulses with `rx_data`=0x3C and `frame_err`=1. No further `rx_valid` until `rx` returns high; the next 0x81 frame gives `frame_err`=0.
- **Back-to-back frames**: 0x00 then 0xFF with no idle gap -> two `rx_valid` pulses, `rx_data` 0x00 then 0xFF, no errors.
- **Parity** (`UART_RX_PARITY_EN` defined): 0x07 sent with parity bit 0 -> `parity_err`=1. Resent with parity bit 1 -> `parity_err`=0.
- **Reset mid-frame**: `reset` asserted during data bit 3 -> all outputs 0 immediately and no `rx_valid`. After release, frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver, transmitter and baud
// generator.
//   rx_state_t        receiver FSM state encoding
//   UART_DATA_BITS    default payload bits per frame
//   UART_SAMPLE_RATE  default oversample ticks per bit period
package uart_pkg;

    localparam int unsigned UART_DATA_BITS   = 8;
    localparam int unsigned UART_SAMPLE_RATE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to RESET_VAL, so an idle-high line does not show a
// spurious edge when reset is released.
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   d_i    in   asynchronous input
//   q_o    out  input synchronised to clk
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receive stage driven by the 16x oversample tick rx_en.
// Finds the start bit, samples every bit at mid-bit and delivers LSB-first
// bytes with a one-cycle rx_valid strobe plus framing/parity status.
//   clk         in   system clock
//   reset       in   asynchronous active-low reset
//   rx_en       in   oversample tick, one clk wide
//   rx          in   asynchronous serial line, idle high
//   rx_data     out  last received payload
//   rx_valid    out  one-cycle strobe per completed frame
//   rx_busy     out  high whenever the FSM is not in IDLE
//   frame_err   out  stop bit of the last frame sampled low
//   parity_err  out  even-parity mismatch on the last frame
// Build option: UART_RX_PARITY_EN adds one even-parity bit before the stop
// bit; without it the frame is 8N1 and parity_err is tied low.
//
// state  | meaning
// IDLE   | line idle, waiting for a low sample
// START  | half a bit into the start bit, re-checking it is still low
// DATA   | sampling payload bits at mid-bit
// PARITY | sampling the parity bit (parity build only)
// STOP   | sampling the stop bit, publishing the frame
// BREAK  | line held low after the stop slot, waiting for it to go high
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = UART_DATA_BITS,
    parameter int unsigned SAMPLE_RATE = UART_SAMPLE_RATE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int unsigned TICK_W = $clog2(SAMPLE_RATE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(SAMPLE_RATE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_RATE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t            state_q,     state_d;
    logic [TICK_W-1:0]    tick_cnt_q,  tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q,   bit_cnt_d;
    logic [DATA_BITS-1:0] shift_reg_q, shift_reg_d;
    logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
    logic                 rx_valid_q,  rx_valid_d;
    logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q,    par_bad_d;
    logic                 parity_err_q, parity_err_d;
`endif

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_reg_q  <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_reg_q  <= shift_reg_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_reg_d  = shift_reg_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;            // strobe self-clears every cycle
        frame_err_d  = frame_err_q;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = parity_err_q;
`endif

        if (rx_en) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end

                START: begin
                    if (tick_cnt_q == TICK_HALF) begin
                        if (!rx_s) begin
                            state_d    = DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            // start bit did not survive to mid-bit: glitch
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end

                DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        // LSB arrives first, so new bits enter at the MSB
                        shift_reg_d                = shift_reg_q >> 1;
                        shift_reg_d[DATA_BITS-1]   = rx_s;
                        tick_cnt_d                 = '0;
                        bit_cnt_d                  = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        par_bad_d  = ^{shift_reg_q, rx_s};
                        tick_cnt_d = '0;
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
`endif

                STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d   = '0;
                        rx_data_d    = shift_reg_q;
                        rx_valid_d   = 1'b1;
                        frame_err_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = par_bad_q;
`endif
                        // a low stop slot may be a break; never restart on it
                        state_d      = rx_s ? IDLE : BREAK;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end

                BREAK: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_busy   = (state_q != IDLE);
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. rx_en ticks every 4 clk,
// 16 ticks per bit, so one bit lasts 64 clk. Table-driven frames followed
// by hand-written corner sequences (glitch, break, back-to-back, parity,
// reset mid-frame). Honours UART_RX_PARITY_EN like the RTL.
module tb_uart_rx;

    localparam int BIT_CLK = 64;

    logic       clk;
    logic       reset;
    logic       rx_en;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       parity_err;

    int n_checks = 0;
    int n_err    = 0;
    int vcount   = 0;
    logic [9:0] log_q[$];
    logic [1:0] tick_div = 2'd0;

    uart_rx #(
        .DATA_BITS   (8),
        .SAMPLE_RATE (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_en      (rx_en),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial rx_en = 1'b0;
    always @(negedge clk) begin
        tick_div = tick_div + 2'd1;
        rx_en    = (tick_div == 2'd0);
    end

    // every cycle with rx_valid high is counted, so a stretched strobe shows
    always @(negedge clk) begin
        if (rx_valid) begin
            vcount = vcount + 1;
            log_q.push_back({parity_err, frame_err, rx_data});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] d, input logic par);
        rx = 1'b0;
        idle(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(BIT_CLK);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        idle(BIT_CLK);
`else
        if (par) begin end
`endif
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_head(d, par);
        rx = stop;
        idle(BIT_CLK);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    vec_t vecs[6];
    int   n0;

    initial begin
        // par = ^data gives correct even parity in the parity build
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[2] = '{8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[3] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[4] = '{8'hFE, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[5] = '{8'h5A, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0};

        reset = 1'b0;
        rx    = 1'b1;
        idle(4);
        check("reset rx_data",    32'(rx_data),    32'h0);
        check("reset rx_valid",   32'(rx_valid),   32'h0);
        check("reset rx_busy",    32'(rx_busy),    32'h0);
        check("reset frame_err",  32'(frame_err),  32'h0);
        check("reset parity_err", 32'(parity_err), 32'h0);
        reset = 1'b1;
        idle(16);

        for (int i = 0; i < 6; i++) begin
            n0 = vcount;
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
            idle(32);
            check($sformatf("vec%0d valid_cycles", i), 32'(vcount - n0), 32'd1);
            check($sformatf("vec%0d rx_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d frame_err", i), 32'(frame_err), 32'(vecs[i].exp_fe));
            check($sformatf("vec%0d parity_err", i), 32'(parity_err), 32'(vecs[i].exp_pe));
            check($sformatf("vec%0d busy_after", i), 32'(rx_busy), 32'h0);
        end

        // start glitch: 4 ticks low, then high
        n0 = vcount;
        rx = 1'b0;
        idle(16);
        check("glitch busy_during", 32'(rx_busy), 32'h1);
        rx = 1'b1;
        idle(BIT_CLK);
        check("glitch no_valid", 32'(vcount - n0), 32'd0);
        check("glitch busy_after", 32'(rx_busy), 32'h0);
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(32);
        check("post_glitch valid", 32'(vcount - n0), 32'd1);
        check("post_glitch data", 32'(rx_data), 32'h3C);

        // framing error followed by a held-low break
        n0 = vcount;
        send_head(8'h3C, 1'b0);
        rx = 1'b0;
        idle(40 * 4);
        check("break valid_once", 32'(vcount - n0), 32'd1);
        check("break data", 32'(rx_data), 32'h3C);
        check("break frame_err", 32'(frame_err), 32'h1);
        check("break busy", 32'(rx_busy), 32'h1);
        idle(BIT_CLK);
        check("break still_once", 32'(vcount - n0), 32'd1);
        rx = 1'b1;
        idle(32);
        check("break busy_after", 32'(rx_busy), 32'h0);
        send_frame(8'h81, 1'b0, 1'b1);
        idle(32);
        check("after_break valid", 32'(vcount - n0), 32'd2);
        check("after_break data", 32'(rx_data), 32'h81);
        check("after_break frame_err", 32'(frame_err), 32'h0);

        // back-to-back frames, no idle between stop and next start
        log_q.delete();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(32);
        check("b2b count", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            check("b2b first",  32'(log_q[0]), 32'h000);
            check("b2b second", 32'(log_q[1]), 32'h0FF);
        end

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b1);
        idle(32);
        check("parity bad data", 32'(rx_data), 32'h07);
        check("parity bad flag", 32'(parity_err), 32'h1);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(32);
        check("parity good flag", 32'(parity_err), 32'h0);
`endif

        // reset in the middle of data bit 3 of 0x5A
        n0 = vcount;
        rx = 1'b0;
        idle(BIT_CLK);
        rx = 1'b0; idle(BIT_CLK);
        rx = 1'b1; idle(BIT_CLK);
        rx = 1'b0; idle(BIT_CLK);
        rx = 1'b1; idle(32);
        #1;
        reset = 1'b0;
        #1;
        check("midreset rx_data", 32'(rx_data), 32'h0);
        check("midreset busy", 32'(rx_busy), 32'h0);
        check("midreset valid", 32'(rx_valid), 32'h0);
        check("midreset frame_err", 32'(frame_err), 32'h0);
        rx = 1'b1;
        idle(8);
        reset = 1'b1;
        idle(BIT_CLK * 6);
        check("midreset no_valid", 32'(vcount - n0), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b1);
        idle(32);
        check("post_reset valid", 32'(vcount - n0), 32'd1);
        check("post_reset data", 32'(rx_data), 32'h5A);
        check("post_reset frame_err", 32'(frame_err), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
